morse_display_sequencer: RTL and testbench
==========================================

MORSE_DISPLAY_SEQUENCER -- requirements
Module: morse_display_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, meaning clock cycles per reveal step (legal range >= 1).
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning the segment polarity (1 = a lit segment is driven 0).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port number  input  4  digit to encode; legal values 0-9.
REQ-006 SHALL have port load  input  1  single-cycle request to latch number.
REQ-007 SHALL have port mode  input  1  sampled with load: 0 = instant, 1 = progressive reveal.
REQ-008 SHALL have port timeout  input  1  level; blanks the displays while high.
REQ-009 SHALL have port logout_from_gamecontrol  input  1  level; blanks the displays while high.
REQ-010 SHALL have port display0..display4  output  7 each  seven-segment {g,f,e,d,c,b,a}; display4 is leftmost and holds the first Morse symbol.
REQ-011 SHALL have port busy  output  1  high while in REVEAL.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a pattern becomes fully shown.

Function
REQ-013 SHALL encode digits as 5 symbols, first to last: 1 .----, 2 ..---, 3 ...--, 4 ....-, 5 ....., 6 -...., 7 --..., 8 ---.., 9 ----., 0 -----.
REQ-014 SHALL use these active-low glyphs, and invert every glyph bit when SEG_ACTIVE_LOW = 0:
- DOT = 7'b0100011
- DASH = 7'b0111111
- BLANK = 7'b1111111
- ERR ("E") = 7'b0000110
REQ-015 SHALL implement the states IDLE, REVEAL, SHOW and BLANKED.
REQ-016 SHALL, in IDLE or SHOW with blanking inactive and load = 1, latch number and mode; all resulting outputs are registered and appear the next cycle.
REQ-017 SHALL, for a latched number of 10-15, drive ERR on all five displays, enter SHOW and pulse done, regardless of mode.
REQ-018 SHALL, for a legal digit with mode = 0, drive all five symbols, enter SHOW and pulse done.
REQ-019 SHALL, for a legal digit with mode = 1, blank all displays, clear the tick counter and reveal count, and enter REVEAL.
REQ-020 SHALL, in REVEAL, add one symbol every TICK_DIV cycles, display4 first and display0 last, with unrevealed displays BLANK.
REQ-021 SHALL, when the 5th symbol appears, enter SHOW, pulse done and drop busy in the same cycle.
REQ-022 SHALL, in REVEAL, ignore load; with TICK_DIV = 1 one symbol appears per cycle.
REQ-023 SHALL size the tick counter at max(1, clog2(TICK_DIV)) bits and wrap it to 0 after TICK_DIV-1.
REQ-024 SHALL, when timeout or logout_from_gamecontrol is high in any state, enter BLANKED on the next cycle: all displays BLANK, busy 0, done 0, any reveal abandoned.
REQ-025 SHALL give blanking priority over a simultaneous load; that load is discarded.
REQ-026 SHALL hold BLANKED while either blanking input is high, then go to IDLE with displays BLANK once both are low.
REQ-027 SHALL, in SHOW, hold the displays until the next load or blanking event; a new load replaces the pattern.

Reset
REQ-028 SHALL, with rst = 0 at a clock edge, enter IDLE, drive all displays BLANK, set busy = 0 and done = 0, and clear the counters and latched digit.
REQ-029 SHALL let reset override all inputs, including a reset asserted mid-reveal.

Structure
REQ-030 SHALL place the glyph constants, the state enum and the digit-to-pattern width constant (5) in shared package morse_pkg.
REQ-031 SHALL instantiate sub-module morse_digit_rom: combinational, 4-bit digit in, 5-bit pattern out (1 = dash) plus a valid flag.

Verification
REQ-032 SHALL cover: reset low 2 cycles -> displays 7'b1111111, busy 0, done 0.
REQ-033 SHALL cover: mode 0, load number 9 -> next cycle display4..0 = DASH, DASH, DASH, DASH, DOT; done high 1 cycle.
REQ-034 SHALL cover, with TICK_DIV = 4: mode 1, load number 3 -> busy high; display4 DOT after 4 cycles; display0 DASH after 20 cycles; done pulses; busy falls.
REQ-035 SHALL cover: load number 12 (4'b1100) -> all displays ERR, done pulse.
REQ-036 SHALL cover: timeout raised mid-reveal together with load -> next cycle all BLANK; loads of 14 and 8 ignored while high; timeout low -> IDLE, still BLANK.
REQ-037 SHALL cover: logout_from_gamecontrol high in SHOW -> BLANK; rst low mid-reveal -> IDLE, BLANK, busy 0.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg: glyphs, FSM state type and pattern width shared by the Morse display sequencer
package morse_pkg;
    localparam int PAT_W = 5;
    localparam logic [6:0] GLYPH_DOT   = 7'b0100011;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_ERR   = 7'b0000110;
    typedef enum logic [1:0] {S_IDLE, S_REVEAL, S_SHOW, S_BLANKED} state_t;
    function automatic logic [6:0] sym_glyph(input logic dash);
        return dash ? GLYPH_DASH : GLYPH_DOT;
    endfunction
endpackage

// File: rtl/morse_digit_rom.sv
// morse_digit_rom: digit to 5-symbol Morse pattern (bit 4 = first symbol, 1 = dash)
// Ports: digit in (4b); pattern out (5b); valid high for digits 0-9.
module morse_digit_rom
    import morse_pkg::*;
(
    input  logic [3:0]       digit,
    output logic [PAT_W-1:0] pattern,
    output logic             valid
);
    always_comb begin
        valid = digit <= 4'd9;
        case (digit)
            4'd0:    pattern = 5'b11111;
            4'd1:    pattern = 5'b01111;
            4'd2:    pattern = 5'b00111;
            4'd3:    pattern = 5'b00011;
            4'd4:    pattern = 5'b00001;
            4'd5:    pattern = 5'b00000;
            4'd6:    pattern = 5'b10000;
            4'd7:    pattern = 5'b11000;
            4'd8:    pattern = 5'b11100;
            4'd9:    pattern = 5'b11110;
            default: pattern = 5'b00000;
        endcase
    end
endmodule

// File: rtl/morse_display_sequencer.sv
// morse_display_sequencer: shows a digit as Morse glyphs on five 7-segment displays, instantly or symbol by symbol
// Ports: clk; rst (sync, active low); number/load/mode request a pattern;
//        timeout/logout_from_gamecontrol blank the displays; display4..display0 (display4 = first symbol);
//        busy high while revealing; done pulses when a pattern is fully shown.
module morse_display_sequencer
    import morse_pkg::*;
#(
    parameter int TICK_DIV       = 50_000_000,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] number,
    input  logic       load,
    input  logic       mode,
    input  logic       timeout,
    input  logic       logout_from_gamecontrol,
    output logic [6:0] display0,
    output logic [6:0] display1,
    output logic [6:0] display2,
    output logic [6:0] display3,
    output logic [6:0] display4,
    output logic       busy,
    output logic       done
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    // Glyphs are held active-low internally; the mask flips them for active-high panels.
    localparam logic [6:0] POL = SEG_ACTIVE_LOW ? 7'h00 : 7'h7f;

    state_t                 state, state_n;
    logic [PAT_W-1:0][6:0]  disp_q, disp_n;
    logic [TW-1:0]          tick_q, tick_n;
    logic [2:0]             rcnt_q, rcnt_n;
    logic [3:0]             digit_q, digit_n;
    logic                   busy_n, done_n;
    logic [3:0]             rom_in;
    logic [PAT_W-1:0]       rom_pat;
    logic                   rom_valid;
    logic [2:0]             idx;
    logic                   blank_req;

    // During a reveal the ROM reads the latched digit; otherwise it looks at the incoming number.
    assign rom_in    = state == S_REVEAL ? digit_q : number;
    assign idx       = 3'd4 - rcnt_q;
    assign blank_req = timeout | logout_from_gamecontrol;

    morse_digit_rom u_rom (
        .digit   (rom_in),
        .pattern (rom_pat),
        .valid   (rom_valid)
    );

    always_comb begin
        state_n = state;
        disp_n  = disp_q;
        tick_n  = tick_q;
        rcnt_n  = rcnt_q;
        digit_n = digit_q;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        if (blank_req) begin
            state_n = S_BLANKED;
            disp_n  = {PAT_W{GLYPH_BLANK}};
            tick_n  = '0;
            rcnt_n  = '0;
        end else begin
            case (state)
                S_IDLE, S_SHOW: if (load) begin
                    digit_n = number;
                    if (!rom_valid) begin
                        disp_n  = {PAT_W{GLYPH_ERR}};
                        state_n = S_SHOW;
                        done_n  = 1'b1;
                    end else if (!mode) begin
                        for (int i = 0; i < PAT_W; i++) disp_n[i] = sym_glyph(rom_pat[i]);
                        state_n = S_SHOW;
                        done_n  = 1'b1;
                    end else begin
                        disp_n  = {PAT_W{GLYPH_BLANK}};
                        tick_n  = '0;
                        rcnt_n  = '0;
                        state_n = S_REVEAL;
                        busy_n  = 1'b1;
                    end
                end
                S_REVEAL: begin
                    busy_n = 1'b1;
                    if (tick_q == TICK_LAST) begin
                        tick_n      = '0;
                        rcnt_n      = rcnt_q + 3'd1;
                        disp_n[idx] = sym_glyph(rom_pat[idx]);
                        if (rcnt_q == 3'd4) begin
                            state_n = S_SHOW;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        tick_n = tick_q + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            disp_q  <= {PAT_W{GLYPH_BLANK}};
            tick_q  <= '0;
            rcnt_q  <= '0;
            digit_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            disp_q  <= disp_n;
            tick_q  <= tick_n;
            rcnt_q  <= rcnt_n;
            digit_q <= digit_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    assign display0 = disp_q[0] ^ POL;
    assign display1 = disp_q[1] ^ POL;
    assign display2 = disp_q[2] ^ POL;
    assign display3 = disp_q[3] ^ POL;
    assign display4 = disp_q[4] ^ POL;
endmodule

// File: tb/tb_morse_display_sequencer.sv
// tb_morse_display_sequencer: table and scoreboard bench for the Morse display sequencer
module tb_morse_display_sequencer;
    localparam int TD = 4;
    localparam logic [6:0] DOT   = 7'b0100011;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] ERR   = 7'b0000110;

    typedef struct {
        logic [3:0]  num;
        logic        mode;
        logic [36:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, load = 1'b0, mode = 1'b0, timeout = 1'b0, logout = 1'b0;
    logic [3:0] number = 4'd0;
    logic [6:0] d0, d1, d2, d3, d4;
    logic busy, done;
    logic [36:0] obs;
    logic [36:0] sb[$];
    vec_t vecs[$];
    int n_checks = 0, n_fail = 0;
    string morse[10] = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

    always #5 clk = ~clk;

    morse_display_sequencer #(.TICK_DIV(TD), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .number(number), .load(load), .mode(mode),
        .timeout(timeout), .logout_from_gamecontrol(logout),
        .display0(d0), .display1(d1), .display2(d2), .display3(d3), .display4(d4),
        .busy(busy), .done(done)
    );

    assign obs = {busy, done, d4, d3, d2, d1, d0};

    // Expected displays after `shown` symbols of digit num (num > 9 -> ERR).
    function automatic logic [34:0] model(int num, int shown);
        logic [34:0] r;
        string s;
        if (num > 9) return {5{ERR}};
        s = morse[num];
        for (int i = 0; i < 5; i++)
            r[34-7*i -: 7] = (i < shown) ? ((s[i] == 8'h2D) ? DASH : DOT) : BLANK;
        return r;
    endfunction

    task automatic chk(string name, logic [36:0] act, logic [36:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got busy/done/disp %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one load, queue what the next cycle must show, then pop and compare.
    task automatic do_load(logic [3:0] num, logic md, logic [36:0] exp, string name);
        number = num;
        mode   = md;
        load   = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        load = 1'b0;
        chk(name, obs, sb.pop_front());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{4'd9,  1'b0, {2'b01, model(9, 5)},  "instant_9"});
        vecs.push_back('{4'd0,  1'b0, {2'b01, model(0, 5)},  "instant_0"});
        vecs.push_back('{4'd1,  1'b0, {2'b01, model(1, 5)},  "instant_1"});
        vecs.push_back('{4'd5,  1'b0, {2'b01, model(5, 5)},  "instant_5"});
        vecs.push_back('{4'd6,  1'b0, {2'b01, model(6, 5)},  "instant_6"});
        vecs.push_back('{4'd8,  1'b0, {2'b01, model(8, 5)},  "instant_8"});
        vecs.push_back('{4'd12, 1'b0, {2'b01, {5{ERR}}},     "err_12"});
        vecs.push_back('{4'd15, 1'b1, {2'b01, {5{ERR}}},     "err_15_mode1"});
        vecs.push_back('{4'd10, 1'b0, {2'b01, {5{ERR}}},     "err_10"});
        vecs.push_back('{4'd7,  1'b0, {2'b01, model(7, 5)},  "instant_7"});

        repeat (2) @(negedge clk);
        chk("reset", obs, {2'b00, {5{BLANK}}});
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", obs, {2'b00, {5{BLANK}}});

        foreach (vecs[i]) begin
            do_load(vecs[i].num, vecs[i].mode, vecs[i].exp, vecs[i].name);
            @(negedge clk);
            chk({vecs[i].name, "_hold"}, obs, {2'b00, vecs[i].exp[34:0]});
        end

        do_load(4'd3, 1'b1, {2'b10, {5{BLANK}}}, "reveal_start");
        for (int k = 1; k <= 21; k++) begin
            if (k == 6) begin
                number = 4'd8;
                mode   = 1'b0;
                load   = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            chk($sformatf("reveal_k%0d", k), obs,
                {(k < 20) ? 1'b1 : 1'b0, (k == 20) ? 1'b1 : 1'b0, model(3, (k > 20 ? 20 : k) / 4)});
        end

        do_load(4'd7, 1'b1, {2'b10, {5{BLANK}}}, "reveal7_start");
        repeat (5) @(negedge clk);
        chk("reveal7_mid", obs, {2'b10, model(7, 1)});
        timeout = 1'b1;
        number  = 4'd14;
        mode    = 1'b0;
        load    = 1'b1;
        @(negedge clk);
        chk("timeout_with_load", obs, {2'b00, {5{BLANK}}});
        number = 4'd14;
        @(negedge clk);
        chk("timeout_load14", obs, {2'b00, {5{BLANK}}});
        number = 4'd8;
        @(negedge clk);
        chk("timeout_load8", obs, {2'b00, {5{BLANK}}});
        load    = 1'b0;
        timeout = 1'b0;
        @(negedge clk);
        chk("timeout_release", obs, {2'b00, {5{BLANK}}});
        repeat (6) @(negedge clk);
        chk("idle_stays_blank", obs, {2'b00, {5{BLANK}}});
        do_load(4'd2, 1'b0, {2'b01, model(2, 5)}, "load_after_blank");

        logout = 1'b1;
        @(negedge clk);
        chk("logout_in_show", obs, {2'b00, {5{BLANK}}});
        logout = 1'b0;
        @(negedge clk);
        chk("logout_release", obs, {2'b00, {5{BLANK}}});

        do_load(4'd4, 1'b1, {2'b10, {5{BLANK}}}, "reveal4_start");
        repeat (6) @(negedge clk);
        chk("reveal4_mid", obs, {2'b10, model(4, 1)});
        rst = 1'b0;
        @(negedge clk);
        chk("reset_mid_reveal", obs, {2'b00, {5{BLANK}}});
        rst = 1'b1;
        repeat (25) @(negedge clk);
        chk("after_reset_no_reveal", obs, {2'b00, {5{BLANK}}});
        do_load(4'd5, 1'b0, {2'b01, model(5, 5)}, "load_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
